// File: rtl/cache_refill_ctrl_if.sv
// Bundle between the data cache, the refill controller and main memory.
// The master modport is the refill controller's view; the slave modport is the cache/memory side.
interface cache_refill_ctrl_if #(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4
);
    logic                             miss_req;
    logic [ADDR_W-1:0]                miss_addr;
    logic                             stall;
    logic                             busy;
    logic                             mem_req;
    logic [ADDR_W-1:0]                mem_addr;
    logic                             mem_ack;
    logic [WORD_W-1:0]                mem_rdata;
    logic [ADDR_W-1:0]                line_addr;
    logic [WORD_W*WORDS_PER_LINE-1:0] line_data;
    logic                             line_we;

    modport master (
        input  miss_req, miss_addr, mem_ack, mem_rdata,
        output stall, busy, mem_req, mem_addr, line_addr, line_data, line_we
    );

    modport slave (
        output miss_req, miss_addr, mem_ack, mem_rdata,
        input  stall, busy, mem_req, mem_addr, line_addr, line_data, line_we
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Data-cache miss handler: fetches one line over a req/ack word port, then writes it into the cache.
// Optional macro CRITICAL_WORD_FIRST_EN starts the fetch at the faulting word and wraps around the line.
module cache_refill_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_refill_ctrl_if.master bus
);
    localparam int CNT_W   = $clog2(WORDS_PER_LINE);
    localparam int BYTE_SH = $clog2(WORD_W / 8);
    localparam int LINE_SH = CNT_W + BYTE_SH;
    localparam int LINE_W  = WORD_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FILL,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  first_word;
    logic [CNT_W-1:0]  slot;
    logic [ADDR_W-1:0] line_addr_q;
    logic [LINE_W-1:0] line_data_q;
    logic              last_ack;

    // Word offset currently being fetched; the narrow add wraps around the line.
    assign slot     = first_word + cnt;
    assign last_ack = bus.mem_ack && (cnt == CNT_W'(WORDS_PER_LINE - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_req and line_we decode the state directly, so an asynchronous reset drops them at once.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch behind.
        state_nxt    = state;
        bus.stall    = 1'b0;
        bus.busy     = (state != IDLE);
        bus.mem_req  = 1'b0;
        bus.mem_addr = '0;
        bus.line_we  = 1'b0;
        case (state)
            IDLE: begin
                bus.stall = bus.miss_req;
                if (bus.miss_req) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = line_addr_q + (ADDR_W'(slot) << BYTE_SH);
                if (last_ack) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                bus.stall   = 1'b1;
                bus.line_we = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: the line buffer is reset too, because line_data is a visible output with a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            first_word  <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_req) begin
                        line_addr_q <= {bus.miss_addr[ADDR_W-1:LINE_SH], LINE_SH'(0)};
                        cnt         <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
                        first_word  <= bus.miss_addr[LINE_SH-1:BYTE_SH];
`else
                        first_word  <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        cnt <= cnt + CNT_W'(1);
                        // Word offset 0 lives in the most significant slot of the line.
                        for (int i = 0; i < WORDS_PER_LINE; i++) begin
                            if (slot == CNT_W'(i)) begin
                                line_data_q[(WORDS_PER_LINE-1-i)*WORD_W +: WORD_W] <= bus.mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.line_addr = line_addr_q;
    assign bus.line_data = line_data_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: a queue-based refill model checked every cycle,
// plus directed refills with hand-computed addresses, line contents and strobe timing.
module tb_cache_refill_ctrl;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk;
    logic rst_n;

    cache_refill_ctrl_if #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(4)) bus ();

    cache_refill_ctrl #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int we_pulses = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int         mem_wait  = 0;
    int         waited    = 0;
    logic [7:0] data_base = 8'h00;
    bit         stray_ack = 1'b0;

    always @(posedge clk) begin
        #2;
        if (stray_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hDEAD_BEEF;
            waited        = 0;
        end else if (bus.mem_req === 1'b1) begin
            if (waited >= mem_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = {24'h0, 8'(data_base + 8'(bus.mem_addr[3:2]))};
                waited        = 0;
            end else begin
                bus.mem_ack = 1'b0;
                waited++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            waited      = 0;
        end
    end

    // ---------------- reference model ----------------
    bit           m_active = 1'b0;
    bit           m_write  = 1'b0;
    bit           m_settle = 1'b0;
    logic [31:0]  m_laddr  = '0;
    logic [127:0] m_line   = '0;
    logic [31:0]  fq[$];
    int           sq[$];
    int           m_w;
    int           m_off;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_write  = 1'b0;
            m_settle = 1'b0;
            m_laddr  = '0;
            m_line   = '0;
            fq.delete();
            sq.delete();
        end else if (!m_active) begin
            if (bus.miss_req === 1'b1) begin
                m_w     = CWF ? int'(bus.miss_addr[3:2]) : 0;
                m_laddr = bus.miss_addr & ~32'hF;
                for (int k = 0; k < 4; k++) begin
                    m_off = (m_w + k) % 4;
                    fq.push_back(m_laddr + 32'(4 * m_off));
                    sq.push_back(m_off);
                end
                m_active = 1'b1;
            end
        end else if (fq.size() != 0) begin
            if (bus.mem_ack === 1'b1) begin
                m_line[127 - 32*sq[0] -: 32] = bus.mem_rdata;
                void'(fq.pop_front());
                void'(sq.pop_front());
                if (fq.size() == 0) m_write = 1'b1;
            end
        end else if (m_write) begin
            m_write  = 1'b0;
            m_settle = 1'b1;
        end else begin
            m_settle = 1'b0;
            m_active = 1'b0;
        end
    end

    bit e_req;
    always @(negedge clk) begin
        e_req = m_active && (fq.size() != 0);
        check("cmp_busy", bus.busy, m_active);
        check("cmp_mem_req", bus.mem_req, e_req);
        if (e_req) check("cmp_mem_addr", bus.mem_addr, fq[0]);
        check("cmp_line_we", bus.line_we, m_write);
        check("cmp_stall", bus.stall, m_active ? !m_settle : bus.miss_req);
        check("cmp_line_addr", bus.line_addr, m_laddr);
        check("cmp_line_data", bus.line_data, m_line);
        if (bus.line_we === 1'b1) we_pulses++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated refill: miss for a single cycle, then literal checks of addresses, strobe and stall timing.
    task automatic refill(input string tag, input logic [31:0] addr, input logic [7:0] dbase, input int wait_cyc,
                          input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [31:0] a3, input int we_cyc, input logic [31:0] la,
                          input logic [127:0] ld);
        logic [31:0] exp_a[4];
        int k;
        int p0;
        exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2; exp_a[3] = a3;
        k  = 0;
        p0 = we_pulses;
        mem_wait  = wait_cyc;
        data_base = dbase;
        step();
        bus.miss_req  = 1'b1;
        bus.miss_addr = addr;
        #2;
        check({tag, "_stall_c0"}, bus.stall, 1'b1);
        for (int c = 1; c <= we_cyc + 2; c++) begin
            step();
            bus.miss_req = 1'b0;
            #2;
            if (bus.mem_ack === 1'b1 && k < 4) begin
                check({tag, "_mem_addr"}, bus.mem_addr, exp_a[k]);
                k++;
            end
            check({tag, "_line_we"}, bus.line_we, (c == we_cyc));
            check({tag, "_stall"}, bus.stall, (c <= we_cyc));
            check({tag, "_busy"}, bus.busy, (c <= we_cyc + 1));
        end
        check({tag, "_ack_count"}, 128'(k), 128'(4));
        check({tag, "_we_pulses"}, 128'(we_pulses - p0), 128'(1));
        check({tag, "_line_addr"}, bus.line_addr, la);
        check({tag, "_line_data"}, bus.line_data, ld);
    endtask

    localparam logic [127:0] LINE_A = 128'h000000A0_000000A1_000000A2_000000A3;
    localparam logic [127:0] LINE_B = 128'h000000B0_000000B1_000000B2_000000B3;
    localparam logic [127:0] LINE_C = 128'h000000C0_000000C1_000000C2_000000C3;
    localparam logic [127:0] LINE_D = 128'h000000D0_000000D1_000000D2_000000D3;
    localparam logic [127:0] LINE_E = 128'h000000E0_000000E1_000000E2_000000E3;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [31:0] SEQ1[4] = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
    localparam logic [31:0] SEQ6[4] = '{32'h1238, 32'h123C, 32'h1230, 32'h1234};
`else
    localparam logic [31:0] SEQ1[4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    localparam logic [31:0] SEQ6[4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
`endif

    int p0;

    initial begin
        rst_n         = 1'b0;
        bus.miss_req  = 1'b0;
        bus.miss_addr = '0;

        // Reset state; stall still follows miss_req while held in reset.
        step();
        #2;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_line_we", bus.line_we, 1'b0);
        check("rst_line_addr", bus.line_addr, 32'h0);
        check("rst_line_data", bus.line_data, 128'h0);
        bus.miss_req = 1'b1;
        #1;
        check("rst_stall_follows_miss", bus.stall, 1'b1);
        check("rst_busy_with_miss", bus.busy, 1'b0);
        step();
        bus.miss_req = 1'b0;
        rst_n        = 1'b1;

        // 1: zero-wait refill.
        refill("t1", 32'h0000_1234, 8'hA0, 0, SEQ1[0], SEQ1[1], SEQ1[2], SEQ1[3], 5, 32'h1230, LINE_A);

        // 2: three wait cycles before every ack.
        refill("t2", 32'h0000_1234, 8'hA0, 3, SEQ1[0], SEQ1[1], SEQ1[2], SEQ1[3], 17, 32'h1230, LINE_A);

        // 3: reset after the second ack aborts the refill without a line write.
        p0        = we_pulses;
        mem_wait  = 0;
        data_base = 8'hA0;
        step();
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0000_5678;
        step();
        bus.miss_req = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t3_mem_req_async", bus.mem_req, 1'b0);
        check("t3_busy_async", bus.busy, 1'b0);
        check("t3_line_we_async", bus.line_we, 1'b0);
        check("t3_line_data_async", bus.line_data, 128'h0);
        step();
        step();
        rst_n = 1'b1;
        check("t3_no_we_pulse", 128'(we_pulses - p0), 128'(0));
        refill("t3", 32'h0000_0040, 8'hC0, 0, 32'h40, 32'h44, 32'h48, 32'h4C, 5, 32'h40, LINE_C);

        // 4: miss_req during FETCH and DONE, and a stray ack in IDLE, are all ignored.
        p0        = we_pulses;
        mem_wait  = 1;
        data_base = 8'hD0;
        step();
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0000_2000;
        for (int c = 1; c <= 14; c++) begin
            step();
            bus.miss_req  = (c == 2 || c == 3 || c == 10);
            bus.miss_addr = 32'h0000_3000;
            stray_ack     = (c == 12);
            #2;
            if (c == 10) check("t4_done_stall", bus.stall, 1'b0);
            if (c == 12) check("t4_idle_busy", bus.busy, 1'b0);
        end
        check("t4_we_pulses", 128'(we_pulses - p0), 128'(1));
        check("t4_line_addr", bus.line_addr, 32'h2000);
        check("t4_line_data", bus.line_data, LINE_D);

        // 5: miss_req held high across two lines; the second address appears at DONE+1.
        p0        = we_pulses;
        mem_wait  = 0;
        data_base = 8'hE0;
        step();
        bus.miss_req  = 1'b1;
        bus.miss_addr = 32'h0000_0100;
        for (int c = 1; c <= 14; c++) begin
            step();
            bus.miss_req  = (c < 13);
            bus.miss_addr = (c >= 7) ? 32'h0000_0200 : 32'h0000_0100;
            #2;
            if (c == 5) begin
                check("t5_we_first", bus.line_we, 1'b1);
                check("t5_addr_first", bus.line_addr, 32'h100);
            end
            if (c == 12) begin
                check("t5_we_second", bus.line_we, 1'b1);
                check("t5_addr_second", bus.line_addr, 32'h200);
            end
        end
        check("t5_we_pulses", 128'(we_pulses - p0), 128'(2));
        check("t5_line_data", bus.line_data, LINE_E);

        // 6: faulting word in the middle of the line; final line layout is the same in both fetch orders.
        refill("t6", 32'h0000_1238, 8'hB0, 0, SEQ6[0], SEQ6[1], SEQ6[2], SEQ6[3], 5, 32'h1230, LINE_B);

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
